mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
Shares the single core-to-memory request port between NUM_REQS requesters (icache miss, dcache miss/evict, TLB walker, ...). The arbiter is round-robin and keeps one transaction outstanding at a time. It latches the winning request, drives it onto the memory port with a valid/ready handshake, and routes the response back to the owner. A response watchdog returns an error response if memory never answers. It sits between the cache miss logic and the memory interface.

Parameters:
- NUM_REQS, 4, number of requesters (>=1).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 128, line data width for write data and read response.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_RSP before an error response (>=2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_ready  out  NUM_REQS  one-hot, one-cycle accept pulse.
- req_is_write  in  NUM_REQS  per-requester write flag.
- req_addr  in  NUM_REQS*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQS*DATA_WIDTH  packed write data, same packing.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_req_is_write  out  1  latched write flag.
- mem_req_addr  out  ADDR_WIDTH  latched address.
- mem_req_wdata  out  DATA_WIDTH  latched write data.
- mem_rsp_valid  in  1  memory response (read data or write ack).
- mem_rsp_data  in  DATA_WIDTH  response data.
- rsp_valid  out  NUM_REQS  one-hot, one-cycle response pulse to owner.
- rsp_data  out  DATA_WIDTH  response data, broadcast; qualified by rsp_valid.
- rsp_error  out  1  response is a timeout error; qualified by rsp_valid.
- err_stray_rsp  out  1  sticky flag: mem_rsp_valid seen outside WAIT_RSP.

Behaviour:
- Reset (async, active-high): state=IDLE. req_ready, rsp_valid, mem_req_valid, rsp_error, err_stray_rsp all 0. Latched addr/wdata/is_write/owner are 0. Watchdog is 0. Round-robin pointer cleared, so requester 0 has highest priority.
- Reset mid-operation aborts the transaction silently; no response is generated.
- IDLE, with any req_valid:
  - Round-robin grant is combinational. req_ready[winner]=1 in the same cycle.
  - On that edge: latch owner, addr, wdata and is_write; pop the arbiter; go to ISSUE.
  - With no req_valid, stay in IDLE and leave the arbiter pointer unchanged.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On a valid & ready edge, go to WAIT_RSP and clear the watchdog.
  - No timeout applies in ISSUE.
- WAIT_RSP:
  - Watchdog increments every cycle.
  - mem_rsp_valid=1: next cycle rsp_valid[owner]=1, rsp_data=mem_rsp_data (registered), rsp_error=0; go to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES-1 without a response: next cycle rsp_valid[owner]=1, rsp_error=1, rsp_data=0; go to IDLE.
  - mem_rsp_valid in the same cycle as the timeout: the response wins and no error is reported.
- Outputs are registered. rsp_valid is a single-cycle pulse with no backpressure; requesters must always sink it.
- Minimum latency is 3 cycles from the accept cycle t:
  - t+1: mem_req_valid asserted.
  - t+2: mem_rsp_valid at the earliest, if mem_req_ready was high at t+1.
  - t+3: rsp_valid.
- The cycle rsp_valid pulses is an IDLE cycle, so back-to-back accept is allowed that cycle.
- mem_rsp_valid in IDLE or ISSUE (e.g. a late response after a timeout) is dropped and sets err_stray_rsp, which stays set until reset.
- Fairness: a requester holding req_valid is accepted within NUM_REQS grants.
- A requester may drop req_valid before acceptance with no effect.
- req_* inputs are sampled only on the accept edge.
- NUM_REQS==1: always grant requester 0.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT_RSP) and the watchdog width constant, $clog2(TIMEOUT_CYCLES).
- Owner index width is $clog2(NUM_REQS), minimum 1.
- Sub-module: instantiate the library round-robin arbiter arb_rr.
  - reqs = req_valid.
  - pop = (state==IDLE) & |req_valid.
  - The grant is one-hot; encode it to the owner index locally.

Test Plan:
- Single read: requester 2 requests addr 0x1000. mem_req_ready=1 immediately; mem_rsp_data=0xAA..AA 2 cycles later. Expect req_ready=4'b0100 at t, mem_req_addr=0x1000 at t+1, rsp_valid=4'b0100 with data 0xAA..AA at t+3.
- Fairness: all 4 requesters hold req_valid continuously; memory responds in 2 cycles. Expect grant order 0,1,2,3,0,1 and no requester starved.
- Backpressure: mem_req_ready low for 5 cycles. Expect mem_req_valid and addr/wdata/is_write stable for all 5 cycles and a single issue.
- Timeout: TIMEOUT_CYCLES=8, memory never responds. Expect rsp_valid[owner]=1 with rsp_error=1 exactly 8 cycles after the handshake. A later mem_rsp_valid must set err_stray_rsp=1 and produce no rsp_valid.
- Race: mem_rsp_valid arrives in the timeout cycle. Expect a single rsp_valid with rsp_error=0 and correct data.
- Async reset asserted in WAIT_RSP. Expect all outputs 0 immediately, no response after release, and the next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the memory request arbiter.
//   arb_state_e  - transaction FSM states (IDLE, ISSUE, WAIT_RSP)
//   idx_width    - owner index width, $clog2(n) with a minimum of 1
//   wdog_width   - response watchdog width, $clog2(timeout_cycles)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The watchdog only has to hold values up to timeout_cycles-1.
    function automatic int wdog_width(input int timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side and memory-side bundle of the arbiter.
//   req_*       - NUM_REQS requesters, fields packed at [i*W +: W]
//   mem_req_*   - single request port toward memory
//   mem_rsp_*   - memory response (read data or write ack)
//   rsp_*       - response routed back to the owning requester
//   err_stray_rsp - sticky flag for unexpected memory responses
// Modports: slave = the arbiter, master = requesters + memory (environment).
//
// Handshake semantics: a request moves on a rising edge where valid and ready
// are both high. The arbiter holds mem_req_valid and all mem_req_* fields
// stable until that edge. req_ready is a one-cycle accept pulse; rsp_valid and
// mem_rsp_valid are single-cycle pulses with no backpressure.
interface mem_req_arbiter_if #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0]            req_ready;
    logic [NUM_REQS-1:0]            req_is_write;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQS*DATA_WIDTH-1:0] req_wdata;
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic                           mem_req_is_write;
    logic [ADDR_WIDTH-1:0]          mem_req_addr;
    logic [DATA_WIDTH-1:0]          mem_req_wdata;
    logic                           mem_rsp_valid;
    logic [DATA_WIDTH-1:0]          mem_rsp_data;
    logic [NUM_REQS-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]          rsp_data;
    logic                           rsp_error;
    logic                           err_stray_rsp;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_wdata,
        output rsp_valid, rsp_data, rsp_error, err_stray_rsp
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_wdata,
        input  rsp_valid, rsp_data, rsp_error, err_stray_rsp
    );
endinterface

// File: rtl/mem_req_arbiter_arb_rr.sv
// arb_rr: round-robin arbiter.
//   clock, reset - clock and asynchronous active-high reset
//   reqs         - request vector
//   pop          - consume the current grant; priority moves past the winner
//   grant        - one-hot combinational grant (all zero when no request)
// After reset requester 0 has the highest priority.
module arb_rr
    import mem_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] reqs,
    input  logic         pop,
    output logic [N-1:0] grant
);
    localparam int IW = idx_width(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] scan_idx;
    logic          found;

    // Scan N positions starting at ptr, wrapping at N (N need not be a power of 2).
    always_comb begin
        grant    = '0;
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(ptr) + k >= N) ? IW'(int'(ptr) + k - N) : IW'(int'(ptr) + k);
            if (!found && reqs[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                winner          = scan_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (pop && found) begin
            ptr <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory request port among NUM_REQS requesters.
// Round-robin grant, one transaction outstanding, response routed to its owner,
// watchdog returns an error response when memory never answers.
//   clock, reset - clock and asynchronous active-high reset
//   bus          - mem_req_arbiter_if.slave (requesters, memory port, responses)
//   dbg_state    - current transaction FSM state
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQS       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    mem_req_arbiter_if.slave        bus,
    output arb_state_e              dbg_state
);
    localparam int IDX_W  = idx_width(NUM_REQS);
    localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);
    // The watchdog steps to TIMEOUT_CYCLES-1 on the edge where it reads this
    // value; that edge launches the error response, so the error pulse lands
    // exactly TIMEOUT_CYCLES cycles after the memory handshake.
    localparam logic [WDOG_W-1:0] WDOG_FIRE = WDOG_W'(TIMEOUT_CYCLES - 2);

    arb_state_e              state;
    logic [NUM_REQS-1:0]     grant;
    logic [NUM_REQS-1:0]     owner_onehot;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        owner;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_is_write;
    logic                    pop;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    is_write_q;
    logic                    mem_req_valid_q;
    logic [WDOG_W-1:0]       wdog;
    logic [NUM_REQS-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_error_q;
    logic                    stray_q;

    assign pop = !reset && (state == IDLE) && (|bus.req_valid);

    arb_rr #(.N(NUM_REQS)) u_arb (
        .clock (clock),
        .reset (reset),
        .reqs  (bus.req_valid),
        .pop   (pop),
        .grant (grant)
    );

    // Encode the one-hot grant and pick out the winner's fields.
    always_comb begin
        grant_idx    = '0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_is_write = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                grant_idx    = IDX_W'(i);
                sel_addr     = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata    = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_is_write = bus.req_is_write[i];
            end
        end
    end

    always_comb begin
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            owner_onehot[i] = (owner == IDX_W'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            is_write_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            wdog            <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            rsp_error_q     <= 1'b0;
            stray_q         <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            // Any response outside WAIT_RSP (e.g. a late one after a timeout) is dropped.
            if (bus.mem_rsp_valid && state != WAIT_RSP) begin
                stray_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        owner           <= grant_idx;
                        addr_q          <= sel_addr;
                        wdata_q         <= sel_wdata;
                        is_write_q      <= sel_is_write;
                        mem_req_valid_q <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        wdog            <= '0;
                        state           <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    wdog <= wdog + WDOG_W'(1);
                    // A response in the timeout cycle takes priority over the error.
                    if (bus.mem_rsp_valid) begin
                        rsp_valid_q <= owner_onehot;
                        rsp_data_q  <= bus.mem_rsp_data;
                        state       <= IDLE;
                    end else if (wdog == WDOG_FIRE) begin
                        rsp_valid_q <= owner_onehot;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_ready is the combinational grant; held low while reset is asserted.
    assign bus.req_ready        = (!reset && state == IDLE) ? grant : '0;
    assign bus.mem_req_valid    = mem_req_valid_q;
    assign bus.mem_req_is_write = is_write_q;
    assign bus.mem_req_addr     = addr_q;
    assign bus.mem_req_wdata    = wdata_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_error        = rsp_error_q;
    assign bus.err_stray_rsp    = stray_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: scenario tasks with inline comparisons against
// a round-robin reference model kept in the bench.
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    arb_state_e dbg_state;
    int checks   = 0;
    int failures = 0;

    mem_req_arbiter_if #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_req_arbiter #(
        .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    int              m_next = 0;             // highest-priority requester
    logic [AW-1:0]   addr_tab[N];
    logic [DW-1:0]   wdata_tab[N];
    logic            wr_tab[N];
    logic [N-1:0]    exp_q[$];               // scoreboard: expected response owners

    function automatic int model_pick(input logic [N-1:0] v);
        int w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && v[(m_next + k) % N]) w = (m_next + k) % N;
        if (w >= 0) m_next = (w + 1) % N;
        return w;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rand_tables();
        for (int i = 0; i < N; i++) begin
            addr_tab[i]  = $urandom;
            wdata_tab[i] = {$urandom, $urandom, $urandom, $urandom};
            wr_tab[i]    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic load_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = addr_tab[i];
            bus.req_wdata[i*DW +: DW] = wdata_tab[i];
            bus.req_is_write[i]       = wr_tab[i];
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        m_next = 0;
        @(posedge clock); #1;
    endtask

    // One transaction: request from 'valids', memory ready after rd stall cycles,
    // response in WAIT_RSP cycle rl (0 = never). Starts and ends 1 unit after a rising edge.
    task automatic do_txn(input logic [N-1:0] valids, input int rd, input int rl,
                          input logic [DW-1:0] rdata,
                          output logic [N-1:0] o_ready, output logic [AW-1:0] o_addr,
                          output logic [DW-1:0] o_wdata, output logic o_wr,
                          output logic o_stable, output int o_hs, output int o_late_mreq,
                          output int o_rsp_k, output logic [N-1:0] o_rsp_v,
                          output logic o_err, output logic [DW-1:0] o_data);
        o_stable = 1'b1; o_hs = 0; o_late_mreq = 0; o_rsp_k = -1;
        o_rsp_v = '0; o_err = 1'b0; o_data = '0;
        o_addr = '0; o_wdata = '0; o_wr = 1'b0;
        load_reqs();
        bus.req_valid = valids;
        @(negedge clock);
        o_ready = bus.req_ready;
        @(posedge clock); #1;
        bus.req_valid = '0;
        for (int i = 0; i <= rd; i++) begin
            bus.mem_req_ready = (i == rd);
            @(negedge clock);
            if (i == 0) begin
                o_addr = bus.mem_req_addr; o_wdata = bus.mem_req_wdata; o_wr = bus.mem_req_is_write;
            end
            if (!bus.mem_req_valid || bus.mem_req_addr !== o_addr ||
                bus.mem_req_wdata !== o_wdata || bus.mem_req_is_write !== o_wr) o_stable = 1'b0;
            if (bus.mem_req_valid && bus.mem_req_ready) o_hs++;
            @(posedge clock); #1;
        end
        bus.mem_req_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            bus.mem_rsp_valid = (k == rl);
            bus.mem_rsp_data  = (k == rl) ? rdata : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            if (bus.mem_req_valid) o_late_mreq++;
            if (bus.rsp_valid != '0) begin
                o_rsp_k = k; o_rsp_v = bus.rsp_valid; o_err = bus.rsp_error; o_data = bus.rsp_data;
            end
            @(posedge clock); #1;
            if (o_rsp_k >= 0) break;
        end
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Observation variables shared by the scenario tasks.
    logic [N-1:0]  t_ready, t_rsp_v;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_data;
    logic          t_wr, t_stable, t_err;
    int            t_hs, t_late, t_k;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req_valid = '1;
        @(negedge clock);
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b want=0", bus.mem_req_valid); end
        checks++; if (bus.rsp_valid !== '0 || bus.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b/%b want=0/0", bus.rsp_valid, bus.rsp_error); end
        checks++; if (bus.err_stray_rsp !== 1'b0) begin failures++; $display("FAIL reset_stray got=%b want=0", bus.err_stray_rsp); end
        checks++; if (bus.mem_req_addr !== '0 || bus.mem_req_wdata !== '0) begin failures++; $display("FAIL reset_latched got=%h want=0", bus.mem_req_addr); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
        bus.req_valid = '0;
        reset  = 1'b0;
        m_next = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] aa;
        int w;
        aa = {16{8'hAA}};
        rand_tables();
        addr_tab[2] = 32'h1000; wr_tab[2] = 1'b0;
        w = model_pick(4'b0100);
        do_txn(4'b0100, 0, 1, aa, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
        checks++; if (t_ready !== onehot(w)) begin failures++; $display("FAIL single_ready got=%b want=%b", t_ready, onehot(w)); end
        checks++; if (t_addr !== 32'h1000 || t_wr !== 1'b0) begin failures++; $display("FAIL single_addr got=%h/%b want=1000/0", t_addr, t_wr); end
        checks++; if (t_stable !== 1'b1 || t_hs != 1) begin failures++; $display("FAIL single_issue got=%b/%0d want=1/1", t_stable, t_hs); end
        checks++; if (t_k != 2) begin failures++; $display("FAIL single_latency got=%0d want=2", t_k); end
        checks++; if (t_rsp_v !== 4'b0100 || t_err !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b/%b want=0100/0", t_rsp_v, t_err); end
        checks++; if (t_data !== aa) begin failures++; $display("FAIL single_data got=%h want=%h", t_data, aa); end
    endtask

    task automatic test_fairness();
        int grants, last, cyc, w;
        logic hs_prev;
        apply_reset();
        rand_tables(); load_reqs();
        exp_q.delete();
        bus.req_valid = '1; bus.mem_req_ready = 1'b1;
        hs_prev = 1'b0; grants = 0; last = 0; cyc = 0;
        while ((grants < 6 || exp_q.size() > 0) && cyc < 80) begin
            if (grants >= 6) bus.req_valid = '0;
            bus.mem_rsp_valid = hs_prev;
            bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            hs_prev = bus.mem_req_valid && bus.mem_req_ready;
            if (bus.rsp_valid != '0) begin
                checks++;
                if (exp_q.size() == 0 || bus.rsp_valid !== exp_q[0]) begin
                    failures++; $display("FAIL fair_rsp_owner got=%b want=%b", bus.rsp_valid, (exp_q.size() > 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bus.req_ready != '0) begin
                w = model_pick(bus.req_valid);
                checks++; if (bus.req_ready !== onehot(w)) begin failures++; $display("FAIL fair_grant got=%b want=%b", bus.req_ready, onehot(w)); end
                if (grants > 0) begin
                    checks++; if (cyc - last != 3) begin failures++; $display("FAIL fair_spacing got=%0d want=3", cyc - last); end
                end
                exp_q.push_back(onehot(w));
                last = cyc; grants++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.req_valid = '0; bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b0;
        checks++; if (grants != 6 || exp_q.size() != 0) begin failures++; $display("FAIL fair_budget got=%0d/%0d want=6/0", grants, exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int w;
        rand_tables();
        w = model_pick(4'b1001);
        do_txn(4'b1001, 5, 2, '1, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
        checks++; if (t_ready !== onehot(w)) begin failures++; $display("FAIL bp_ready got=%b want=%b", t_ready, onehot(w)); end
        checks++; if (t_stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b want=1", t_stable); end
        checks++; if (t_hs != 1 || t_late != 0) begin failures++; $display("FAIL bp_single_issue got=%0d/%0d want=1/0", t_hs, t_late); end
        checks++; if (t_addr !== addr_tab[w] || t_wdata !== wdata_tab[w] || t_wr !== wr_tab[w]) begin
            failures++; $display("FAIL bp_fields got=%h want=%h", t_addr, addr_tab[w]); end
        checks++; if (t_k != 3 || t_rsp_v !== onehot(w)) begin failures++; $display("FAIL bp_rsp got=%0d/%b want=3/%b", t_k, t_rsp_v, onehot(w)); end
    endtask

    task automatic test_timeout();
        int w, seen;
        rand_tables();
        w = model_pick(4'b0010);
        do_txn(4'b0010, 1, 0, '0, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
        checks++; if (t_k != TO) begin failures++; $display("FAIL timeout_cycle got=%0d want=%0d", t_k, TO); end
        checks++; if (t_rsp_v !== onehot(w) || t_err !== 1'b1 || t_data !== '0) begin
            failures++; $display("FAIL timeout_rsp got=%b/%b/%h want=%b/1/0", t_rsp_v, t_err, t_data, onehot(w)); end
        checks++; if (bus.err_stray_rsp !== 1'b0) begin failures++; $display("FAIL stray_before got=%b want=0", bus.err_stray_rsp); end
        bus.mem_rsp_valid = 1'b1;
        @(posedge clock); #1;
        bus.mem_rsp_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.rsp_valid != '0) seen++;
            @(posedge clock); #1;
        end
        checks++; if (bus.err_stray_rsp !== 1'b1) begin failures++; $display("FAIL stray_set got=%b want=1", bus.err_stray_rsp); end
        checks++; if (seen != 0) begin failures++; $display("FAIL stray_no_rsp got=%0d want=0", seen); end
    endtask

    task automatic test_race();
        int w;
        logic [DW-1:0] d;
        rand_tables();
        d = {$urandom, $urandom, $urandom, $urandom};
        w = model_pick(4'b1100);
        do_txn(4'b1100, 0, TO - 1, d, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
        checks++; if (t_k != TO || t_rsp_v !== onehot(w)) begin failures++; $display("FAIL race_rsp got=%0d/%b want=%0d/%b", t_k, t_rsp_v, TO, onehot(w)); end
        checks++; if (t_err !== 1'b0 || t_data !== d) begin failures++; $display("FAIL race_data got=%b/%h want=0/%h", t_err, t_data, d); end
    endtask

    task automatic test_reset_midway();
        int seen, w;
        rand_tables(); load_reqs();
        bus.req_valid = 4'b0100;
        @(posedge clock); #1;
        bus.req_valid = '0; bus.mem_req_ready = 1'b1;
        @(posedge clock); #1;
        bus.mem_req_ready = 1'b0;
        @(posedge clock); #1;
        bus.req_valid = 4'b1010;
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.rsp_error !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs got=%b/%b/%b want=0/0/0", bus.mem_req_valid, bus.req_ready, bus.rsp_valid); end
        checks++; if (bus.err_stray_rsp !== 1'b0 || bus.mem_req_addr !== '0 || dbg_state !== IDLE) begin
            failures++; $display("FAIL midreset_state got=%b/%h/%0d want=0/0/0", bus.err_stray_rsp, bus.mem_req_addr, dbg_state); end
        bus.req_valid = '0;
        @(negedge clock); @(negedge clock);
        reset  = 1'b0;
        m_next = 0;
        seen   = 0;
        repeat (TO + 4) begin
            @(negedge clock);
            if (bus.rsp_valid != '0 || bus.mem_req_valid) seen++;
        end
        @(posedge clock); #1;
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_rsp got=%0d want=0", seen); end
        w = model_pick(4'b1010);
        do_txn(4'b1010, 0, 1, '1, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
        checks++; if (t_ready !== onehot(w)) begin failures++; $display("FAIL midreset_grant got=%b want=%b", t_ready, onehot(w)); end
    endtask

    task automatic test_random();
        int w, rd, rl, exp_k;
        logic [N-1:0] v;
        logic [DW-1:0] d;
        for (int n = 0; n < 24; n++) begin
            rand_tables();
            v  = N'($urandom_range(1, (1 << N) - 1));
            rd = $urandom_range(0, 3);
            rl = $urandom_range(0, TO - 1);
            d  = {$urandom, $urandom, $urandom, $urandom};
            w  = model_pick(v);
            exp_k = (rl == 0) ? TO : rl + 1;
            do_txn(v, rd, rl, d, t_ready, t_addr, t_wdata, t_wr, t_stable, t_hs, t_late, t_k, t_rsp_v, t_err, t_data);
            checks++; if (t_ready !== onehot(w)) begin failures++; $display("FAIL rand_grant n=%0d got=%b want=%b", n, t_ready, onehot(w)); end
            checks++; if (t_addr !== addr_tab[w] || t_wdata !== wdata_tab[w] || t_wr !== wr_tab[w] || t_stable !== 1'b1 || t_hs != 1) begin
                failures++; $display("FAIL rand_issue n=%0d got=%h/%b want=%h/%b", n, t_addr, t_wr, addr_tab[w], wr_tab[w]); end
            checks++; if (t_k != exp_k || t_rsp_v !== onehot(w)) begin
                failures++; $display("FAIL rand_rsp n=%0d got=%0d/%b want=%0d/%b", n, t_k, t_rsp_v, exp_k, onehot(w)); end
            checks++; if (t_err !== (rl == 0) || t_data !== ((rl == 0) ? '0 : d)) begin
                failures++; $display("FAIL rand_data n=%0d got=%b/%h want=%b", n, t_err, t_data, rl == 0); end
        end
        checks++; if (bus.err_stray_rsp !== 1'b0) begin failures++; $display("FAIL rand_stray got=%b want=0", bus.err_stray_rsp); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.req_valid     = '0;
        bus.req_is_write  = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        reset = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_midway();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
